// File: rtl/io_bus_if.sv
// Control side of the multiplexed I/O bus.
// The bus master drives the strobes and the bank returns READY.
interface io_bus_if;
  logic        ALE;
  logic        IOM;
  logic        RD;
  logic        WR;
  logic [15:0] Address;
  logic        READY;

  modport master (
    output ALE, IOM, RD, WR, Address,
    input  READY
  );

  modport slave (
    input  ALE, IOM, RD, WR, Address,
    output READY
  );
endinterface

// File: rtl/io_port_bank.sv
// Bank of bus-mapped I/O port registers.
// The bus cycle runs T1, T2, optional TW wait states, T3 and T4.
module io_port_bank #(
  parameter int                DATA_W  = 8,
  parameter logic [15:0]       BASE    = 16'hFF00,
  parameter int                NPORTS  = 16,
  parameter int                WAIT_ST = 1,
  parameter logic [NPORTS-1:0] RO_MASK = '0
) (
  input  logic                     CLK,
  input  logic                     RESET,
  io_bus_if.slave                  bus,
  inout  wire  [DATA_W-1:0]        Data,
  input  logic [NPORTS*DATA_W-1:0] PIN_IN,
  output logic [NPORTS*DATA_W-1:0] PORT_Q,
  output logic [NPORTS-1:0]        WSTB
);

  localparam int         IW = $clog2(NPORTS);
  localparam logic [1:0] WS = 2'(WAIT_ST);

  typedef enum logic [2:0] {
    T1   = 3'd0,
    T2   = 3'd1,
    TW   = 3'd2,
    T3_R = 3'd3,
    T3_W = 3'd4,
    T4   = 3'd5
  } state_t;

  state_t            state;
  state_t            nxt;
  logic [IW-1:0]     idx;
  logic [1:0]        wcnt;
  logic              is_wr;
  logic              hit;
  logic              wr_hit;
  logic              oe;
  logic [DATA_W-1:0] rdata;

  // BASE is aligned, so the upper address bits alone decide the hit.
  assign hit = bus.ALE && bus.IOM &&
               (bus.Address[15:IW] == BASE[15:IW]);

  assign wr_hit = (state == T3_W) && !bus.WR && !RO_MASK[idx];

  assign rdata = RO_MASK[idx] ? PIN_IN[idx*DATA_W +: DATA_W]
                              : PORT_Q[idx*DATA_W +: DATA_W];

  assign oe = !RESET && (state == T3_R) && !bus.RD;

  assign Data = oe ? rdata : 'z;

  assign bus.READY = RESET || (state != TW);

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= T1;
    else       state <= nxt;
  end

  // Latched port index, wait counter and direction decoded in T2.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      idx   <= '0;
      wcnt  <= '0;
      is_wr <= 1'b0;
    end else begin
      if (state == T1 && hit) idx <= bus.Address[IW-1:0];
      if (state == T2) begin
        wcnt  <= WS;
        is_wr <= !bus.WR;
      end else if (state == TW) begin
        wcnt  <= wcnt - 2'd1;
      end
    end
  end

  // Port capture at the edge leaving T3_W, strobe shown the cycle after.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      PORT_Q <= '0;
      WSTB   <= '0;
    end else begin
      WSTB <= '0;
      if (wr_hit) begin
        PORT_Q[idx*DATA_W +: DATA_W] <= Data;
        WSTB[idx]                    <= 1'b1;
      end
    end
  end

  // Next-state decode; a hit outside T1 has no effect.
  always_comb begin
    nxt = state;
    unique case (state)
      T1: if (hit) nxt = T2;
      T2: begin
        unique case (1'b1)
          (!bus.RD &&  bus.WR): nxt = (WS != 2'd0) ? TW : T3_R;
          ( bus.RD && !bus.WR): nxt = (WS != 2'd0) ? TW : T3_W;
          (!bus.RD && !bus.WR): nxt = T4;
          default:              nxt = T2;
        endcase
      end
      TW:   if (wcnt == 2'd1) nxt = is_wr ? T3_W : T3_R;
      T3_R: nxt = T4;
      T3_W: nxt = T4;
      T4:   nxt = T1;
      default: nxt = T1;
    endcase
  end

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank.
// Bank A: defaults with port 5 read-only; bank B: three wait states.
module tb_io_port_bank;

  localparam logic [2:0] S_T1  = 3'd0;
  localparam logic [2:0] S_T2  = 3'd1;
  localparam logic [2:0] S_TW  = 3'd2;
  localparam logic [2:0] S_T3R = 3'd3;
  localparam logic [2:0] S_T3W = 3'd4;
  localparam logic [2:0] S_T4  = 3'd5;

  logic CLK;
  logic RESET;

  logic         ale_a, iom_a, rd_a, wr_a;
  logic [15:0]  addr_a;
  logic         drv_a;
  logic [7:0]   dval_a;
  logic [127:0] pin_a;
  logic [127:0] qa;
  logic [15:0]  wa;
  wire  [7:0]   da;

  logic         ale_b, iom_b, rd_b, wr_b;
  logic [15:0]  addr_b;
  logic [127:0] pin_b;
  logic [127:0] qb;
  logic [15:0]  wb;
  wire  [7:0]   db;

  int vectors;
  int errors;

  io_bus_if ifa ();
  io_bus_if ifb ();

  assign ifa.ALE     = ale_a;
  assign ifa.IOM     = iom_a;
  assign ifa.RD      = rd_a;
  assign ifa.WR      = wr_a;
  assign ifa.Address = addr_a;
  assign da = drv_a ? dval_a : 'z;
  pullup (da);

  assign ifb.ALE     = ale_b;
  assign ifb.IOM     = iom_b;
  assign ifb.RD      = rd_b;
  assign ifb.WR      = wr_b;
  assign ifb.Address = addr_b;
  pullup (db);

  io_port_bank #(
    .RO_MASK (16'h0020)
  ) dut_a (
    .CLK    (CLK),
    .RESET  (RESET),
    .bus    (ifa.slave),
    .Data   (da),
    .PIN_IN (pin_a),
    .PORT_Q (qa),
    .WSTB   (wa)
  );

  io_port_bank #(
    .WAIT_ST (3)
  ) dut_b (
    .CLK    (CLK),
    .RESET  (RESET),
    .bus    (ifb.slave),
    .Data   (db),
    .PIN_IN (pin_b),
    .PORT_Q (qb),
    .WSTB   (wb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sl(input logic [127:0] v, input int i);
    return v[i*8 +: 8];
  endfunction

  initial begin
    vectors = 0;
    errors  = 0;
    RESET   = 1'b1;
    ale_a = 0; iom_a = 0; rd_a = 1; wr_a = 1; addr_a = '0;
    drv_a = 0; dval_a = '0;
    ale_b = 0; iom_b = 0; rd_b = 1; wr_b = 1; addr_b = '0;
    pin_a = '0;
    pin_a[5*8 +: 8] = 8'h3C;
    pin_a[3*8 +: 8] = 8'h5A;
    pin_b = {16{8'h99}};
    tick();
    tick();

    chk("rst_state", 128'(dut_a.state), 128'(S_T1));
    chk("rst_portq", qa, '0);
    chk("rst_wstb", 128'(wa), '0);
    chk("rst_ready", 128'(ifa.READY), 128'(1'b1));
    chk("rst_data_z", 128'(da), 128'h00FF);
    RESET = 1'b0;

    // write A5 to FF03
    ale_a = 1; iom_a = 1; addr_a = 16'hFF03;
    tick();
    chk("w_t2", 128'(dut_a.state), 128'(S_T2));
    ale_a = 0; wr_a = 0; drv_a = 1; dval_a = 8'hA5;
    tick();
    chk("w_tw_ready", 128'(ifa.READY), 128'(1'b0));
    tick();
    chk("w_t3_ready", 128'(ifa.READY), 128'(1'b1));
    chk("w_t3_state", 128'(dut_a.state), 128'(S_T3W));
    tick();
    chk("w_q3", 128'(sl(qa, 3)), 128'h00A5);
    chk("w_wstb", 128'(wa), 128'h0008);
    wr_a = 1; drv_a = 0;
    tick();
    chk("w_wstb_clr", 128'(wa), '0);
    chk("w_idle", 128'(dut_a.state), 128'(S_T1));

    // read back FF03
    ale_a = 1; addr_a = 16'hFF03;
    tick();
    ale_a = 0; rd_a = 0;
    chk("r_t2_z", 128'(da), 128'h00FF);
    tick();
    chk("r_tw_z", 128'(da), 128'h00FF);
    tick();
    chk("r_t3_data", 128'(da), 128'h00A5);
    tick();
    chk("r_t4_z", 128'(da), 128'h00FF);
    rd_a = 1;
    tick();

    // read-only port 5 read
    ale_a = 1; addr_a = 16'hFF05;
    tick();
    ale_a = 0; rd_a = 0;
    tick();
    tick();
    chk("ro_read", 128'(da), 128'h003C);
    tick();
    rd_a = 1;
    tick();

    // read-only port 5 write attempt
    ale_a = 1; addr_a = 16'hFF05;
    tick();
    ale_a = 0; wr_a = 0; drv_a = 1; dval_a = 8'hFF;
    tick();
    tick();
    tick();
    chk("ro_q5", 128'(sl(qa, 5)), '0);
    chk("ro_wstb", 128'(wa), '0);
    wr_a = 1; drv_a = 0;
    tick();

    // memory cycle and out-of-range address are ignored
    ale_a = 1; iom_a = 0; addr_a = 16'hFF02;
    tick();
    ale_a = 0;
    chk("flt_mem_state", 128'(dut_a.state), 128'(S_T1));
    chk("flt_mem_z", 128'(da), 128'h00FF);
    ale_a = 1; iom_a = 1; addr_a = 16'hFF10;
    tick();
    ale_a = 0;
    chk("flt_rng_state", 128'(dut_a.state), 128'(S_T1));
    wr_a = 0; drv_a = 1; dval_a = 8'hEE;
    tick();
    chk("flt_wstb1", 128'(wa), '0);
    tick();
    chk("flt_wstb2", 128'(wa), '0);
    wr_a = 1; drv_a = 0;
    chk("flt_portq", qa, 128'hA5 << 24);

    // RD and WR low together in T2
    ale_a = 1; addr_a = 16'hFF03;
    tick();
    ale_a = 0; rd_a = 0; wr_a = 0;
    tick();
    chk("both_t4", 128'(dut_a.state), 128'(S_T4));
    chk("both_z", 128'(da), 128'h00FF);
    tick();
    chk("both_idle", 128'(dut_a.state), 128'(S_T1));
    chk("both_portq", qa, 128'hA5 << 24);
    chk("both_wstb", 128'(wa), '0);
    rd_a = 1; wr_a = 1;

    // WR withdrawn before T3_W
    ale_a = 1; addr_a = 16'hFF02;
    tick();
    ale_a = 0; wr_a = 0; drv_a = 1; dval_a = 8'h66;
    tick();
    wr_a = 1;
    tick();
    tick();
    chk("early_q2", 128'(sl(qa, 2)), '0);
    chk("early_wstb", 128'(wa), '0);
    drv_a = 0;
    tick();

    // address moves after ALE; a second ALE in TW is ignored
    ale_a = 1; addr_a = 16'hFF01;
    tick();
    ale_a = 0; addr_a = 16'hFF09;
    wr_a = 0; drv_a = 1; dval_a = 8'hC3;
    tick();
    ale_a = 1; addr_a = 16'hFF0A;
    tick();
    chk("live_t3w", 128'(dut_a.state), 128'(S_T3W));
    ale_a = 0;
    tick();
    chk("live_q1", 128'(sl(qa, 1)), 128'h00C3);
    chk("live_q9", 128'(sl(qa, 9)), '0);
    chk("live_qa", 128'(sl(qa, 10)), '0);
    chk("live_wstb", 128'(wa), 128'h0002);
    wr_a = 1; drv_a = 0;
    tick();

    // reset during TW of a write to FF01
    ale_a = 1; addr_a = 16'hFF01;
    tick();
    ale_a = 0; wr_a = 0; drv_a = 1; dval_a = 8'h77;
    tick();
    chk("abort_tw", 128'(dut_a.state), 128'(S_TW));
    RESET = 1'b1;
    tick();
    chk("abort_portq", qa, '0);
    chk("abort_ready", 128'(ifa.READY), 128'(1'b1));
    chk("abort_state", 128'(dut_a.state), 128'(S_T1));
    chk("abort_wstb", 128'(wa), '0);
    RESET = 1'b0; wr_a = 1; drv_a = 0;
    tick();
    chk("abort_wstb2", 128'(wa), '0);
    tick();
    chk("abort_portq2", qa, '0);

    // three wait states on bank B
    ale_b = 1; iom_b = 1; addr_b = 16'hFF00;
    tick();
    chk("b_t2", 128'(dut_b.state), 128'(S_T2));
    chk("b_t2_ready", 128'(ifb.READY), 128'(1'b1));
    ale_b = 0; rd_b = 0;
    tick();
    chk("b_tw1", 128'(dut_b.state), 128'(S_TW));
    chk("b_tw1_ready", 128'(ifb.READY), 128'(1'b0));
    tick();
    chk("b_tw2_ready", 128'(ifb.READY), 128'(1'b0));
    tick();
    chk("b_tw3_ready", 128'(ifb.READY), 128'(1'b0));
    tick();
    chk("b_t3r", 128'(dut_b.state), 128'(S_T3R));
    chk("b_t3r_ready", 128'(ifb.READY), 128'(1'b1));
    chk("b_t3r_data", 128'(db), '0);
    tick();
    chk("b_t4", 128'(dut_b.state), 128'(S_T4));
    chk("b_t4_z", 128'(db), 128'h00FF);
    rd_b = 1;
    tick();
    chk("b_t1", 128'(dut_b.state), 128'(S_T1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/io_port_bank.md
IO_PORT_BANK -- requirements
Module: io_port_bank

Interface
REQ-001 Parameter DATA_W, default 8, data bus and port register width in bits.
REQ-002 Parameter BASE, default 16'hFF00, I/O base address, aligned to NPORTS.
REQ-003 Parameter NPORTS, default 16, number of port registers, power of two, 2..256.
REQ-004 Parameter WAIT_ST, default 1, wait states per access, range 0..3.
REQ-005 Parameter RO_MASK, default '0, NPORTS bits; bit i set means port i is read-only and reads PIN_IN slice i.
REQ-006 CLK  input  1  clock; all state updates on the rising edge.
REQ-007 RESET  input  1  reset; synchronous, active-high.
REQ-008 ALE  input  1  address latch enable, active-high.
REQ-009 IOM  input  1  1 = I/O cycle, 0 = memory cycle (ignored).
REQ-010 RD  input  1  read strobe, active-low.
REQ-011 WR  input  1  write strobe, active-low.
REQ-012 Address  input  16  bus address; sampled only while ALE is high.
REQ-013 Data  inout  DATA_W  bidirectional data bus.
REQ-014 READY  output  1  1 = bus may proceed; 0 = insert wait state.
REQ-015 PIN_IN  input  NPORTS*DATA_W  external inputs for read-only ports; slice i = bits [i*DATA_W +: DATA_W].
REQ-016 PORT_Q  output  NPORTS*DATA_W  registered contents of all ports, same slicing.
REQ-017 WSTB  output  NPORTS  one-cycle pulse on bit i when port i is written.

Function
REQ-018 The block SHALL hit when ALE=1, IOM=1 and BASE <= Address <= BASE+NPORTS-1.
REQ-019 The block SHALL latch the port index Address[log2(NPORTS)-1:0] into an internal register on a hit; the latched index, not the live Address, SHALL select the port for the rest of the cycle.
REQ-020 The state machine SHALL have states T1 (idle), T2 (decode), TW (wait), T3_R, T3_W and T4.
REQ-021 T1 SHALL go to T2 on a hit and otherwise stay in T1.
REQ-022 T2 transitions: RD=0 and WR=1 goes to TW (WAIT_ST>0) or T3_R; WR=0 and RD=1 goes to TW or T3_W; RD=0 and WR=0 goes to T4 with no access; otherwise T2 holds.
REQ-023 TW SHALL last exactly WAIT_ST cycles, counted by a 2-bit counter loaded in T2, then go to T3_R or T3_W as decoded in T2.
REQ-024 READY SHALL be 0 in every TW cycle and 1 in all other states.
REQ-025 T3_R, T3_W and T4 SHALL each last one cycle: T3_R goes to T4, T3_W goes to T4, T4 goes to T1.
REQ-026 Data SHALL be driven only when state is T3_R and RD=0; otherwise Data SHALL be high-Z.
REQ-027 The driven value SHALL be PIN_IN slice if the RO_MASK bit is set, else PORT_Q slice, selected by the latched index.
REQ-028 In T3_W with WR=0, the block SHALL capture Data into the selected port at the clock edge that leaves T3_W, unless the port is read-only.
REQ-029 WSTB[index] SHALL be 1 in the cycle after that capture and 0 otherwise.
REQ-030 If WR=1 in T3_W (strobe withdrawn early), or the port is read-only, the block SHALL make no write and no WSTB pulse.
REQ-031 Memory cycles (IOM=0) and out-of-range addresses SHALL leave state, ports, Data and READY unaffected.
REQ-032 A new ALE hit outside T1 SHALL be ignored; it SHALL NOT restart the current cycle.

Reset
REQ-033 While RESET=1, the block SHALL set: state T1, all port registers 0, PORT_Q 0, WSTB 0, READY 1, Data high-Z, wait counter 0, latched index 0.
REQ-034 RESET asserted mid-cycle, in any state, SHALL abort that cycle with no port write and no WSTB pulse.
REQ-035 No port contents SHALL survive reset; there SHALL be no file preload.

Verification
REQ-036 Write then read, defaults: ALE hit at 16'hFF03, then WR=0 with Data=8'hA5 -> READY=0 for 1 cycle, PORT_Q slice 3 = 8'hA5, WSTB=16'h0008 for one cycle; a later read of 16'hFF03 drives 8'hA5 in T3_R only.
REQ-037 Wait states: WAIT_ST=3, read of 16'hFF00 -> READY=0 for exactly 3 consecutive cycles; the ALE-to-T4 sequence is T1,T2,TW,TW,TW,T3_R,T4.
REQ-038 Decode filtering: ALE with IOM=0 at 16'hFF02, then ALE with IOM=1 at 16'hFF10 -> state stays T1, Data stays high-Z, no WSTB pulse.
REQ-039 Read-only port: RO_MASK bit 5 set, PIN_IN slice 5 = 8'h3C -> reading 16'hFF05 returns 8'h3C; writing 8'hFF to it leaves PORT_Q slice 5 at 0 with no WSTB pulse.
REQ-040 Error and abort: RD=0 and WR=0 together in T2 -> T4 with no access. RESET asserted during TW of a write of 8'h77 to 16'hFF01 -> PORT_Q all zero, READY=1, state T1.
REQ-041 Live address change: Address moved to 16'hFF09 after ALE falls in a write to 16'hFF01 -> only port 1 is written.
